// File: rtl/dac_spi_tx.sv
// dac_spi_tx
// Serialises one 12-bit DAC code into a 16-bit SPI mode-0 frame
// ({CFG_BITS, code}, MSB first). The frame is followed by a short hold
// with chip select still low, then a dac_ldac_n strobe once chip select
// has been released.
//
// Frame timeline, in clk cycles after the accepting edge:
//   SETUP  HALF_PERIOD       cs_n low, sclk low, bit 15 already on mosi
//   SHIFT  32*HALF_PERIOD    16 sclk periods, low phase first
//   HOLD   HALF_PERIOD       cs_n low, sclk low
//   LDAC   HALF_PERIOD       cs_n high, ldac_n low
// sample_ready rises again on edge 35*HALF_PERIOD. Because of that, two
// frames sent back to back are separated by exactly one IDLE cycle.

module dac_spi_tx #(
   parameter int unsigned AMP_WIDTH   = 12,
   parameter int unsigned HALF_PERIOD = 2,
   parameter logic [3:0]  CFG_BITS    = 4'b0011
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [AMP_WIDTH-1:0] sample_data,
   input  logic                 sample_valid,
   output logic                 sample_ready,
   output logic                 dac_cs_n,
   output logic                 dac_sclk,
   output logic                 dac_mosi,
   output logic                 dac_ldac_n,
   output logic                 busy
);

   // Frame layout: 4 configuration bits above the sample code.
   localparam int unsigned FRAME_W = 4 + AMP_WIDTH;

   // The half-period counter only has to reach HALF_PERIOD-1.
   localparam int unsigned    HW        = $clog2(HALF_PERIOD + 1);
   localparam logic [HW-1:0]  HALF_LAST = HW'(HALF_PERIOD - 1);
   localparam logic [HW-1:0]  HALF_ONE  = HW'(1);

   // Index of the last bit of the frame. At 16 bits it fits the 4-bit counter.
   localparam logic [3:0]     BIT_LAST  = 4'(FRAME_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      LDAC
   } state_t;

   state_t               state;
   logic [HW-1:0]        half_cnt;
   logic [3:0]           bit_cnt;
   logic [FRAME_W-1:0]   shift_reg;
   logic                 half_done;

   // The current phase ends when the half-period counter reaches its last value.
   assign half_done = (half_cnt == HALF_LAST);

   // Single registered FSM. Every SPI-side output is a flip-flop, so no
   // input reaches a pin through combinational logic.
   // NOTE: all state here uses non-blocking assignments. Each branch can then
   // read the pre-edge values of dac_sclk and shift_reg, whatever order the
   // statements are written in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         half_cnt     <= '0;
         bit_cnt      <= '0;
         // NOTE: the shift register is reset too. It is small, and clearing it
         // keeps an aborted frame from leaving stale data behind.
         shift_reg    <= '0;
         sample_ready <= 1'b1;
         busy         <= 1'b0;
         dac_cs_n     <= 1'b1;
         dac_sclk     <= 1'b0;
         dac_mosi     <= 1'b0;
         dac_ldac_n   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               // Accept: capture the whole frame now, so that sample_data is
               // free to change from the next cycle on.
               if (sample_valid) begin
                  shift_reg    <= {CFG_BITS, sample_data};
                  dac_mosi     <= CFG_BITS[3];
                  dac_cs_n     <= 1'b0;
                  dac_sclk     <= 1'b0;
                  sample_ready <= 1'b0;
                  busy         <= 1'b1;
                  half_cnt     <= '0;
                  bit_cnt      <= '0;
                  state        <= SETUP;
               end
            end

            SETUP: begin
               // Chip select is low and bit 15 is settling before the first sclk.
               if (half_done) begin
                  half_cnt <= '0;
                  state    <= SHIFT;
               end else begin
                  half_cnt <= half_cnt + HALF_ONE;
               end
            end

            SHIFT: begin
               if (!half_done) begin
                  half_cnt <= half_cnt + HALF_ONE;
               end else begin
                  half_cnt <= '0;
                  if (!dac_sclk) begin
                     // End of the low phase: raise sclk. The DAC samples the
                     // data bit on this edge.
                     dac_sclk <= 1'b1;
                  end else begin
                     // End of the high phase: lower sclk and put the next bit on mosi.
                     dac_sclk <= 1'b0;
                     if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        dac_mosi <= 1'b0;
                        state    <= HOLD;
                     end else begin
                        bit_cnt   <= bit_cnt + 4'd1;
                        dac_mosi  <= shift_reg[FRAME_W-2];
                        shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
                     end
                  end
               end
            end

            HOLD: begin
               // Keep chip select low briefly after the last clock, then release it.
               if (half_done) begin
                  half_cnt   <= '0;
                  dac_cs_n   <= 1'b1;
                  dac_ldac_n <= 1'b0;
                  state      <= LDAC;
               end else begin
                  half_cnt <= half_cnt + HALF_ONE;
               end
            end

            LDAC: begin
               // Latch strobe is active. When it ends the block is ready again.
               if (half_done) begin
                  half_cnt     <= '0;
                  dac_ldac_n   <= 1'b1;
                  sample_ready <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end else begin
                  half_cnt <= half_cnt + HALF_ONE;
               end
            end

            // NOTE: unused encodings return to a clean idle rather than hanging.
            default: begin
               state        <= IDLE;
               half_cnt     <= '0;
               bit_cnt      <= '0;
               sample_ready <= 1'b1;
               busy         <= 1'b0;
               dac_cs_n     <= 1'b1;
               dac_sclk     <= 1'b0;
               dac_mosi     <= 1'b0;
               dac_ldac_n   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx
// Three dac_spi_tx instances, with HALF_PERIOD = 2, 1 and 255. A monitor
// rebuilds each frame from mosi, sampled on sclk rising edges, and compares
// it against a queue of expected frames. Directed steps check the timing of
// cs_n, ldac_n and ready, back-to-back streaming, input changes during a
// frame, a reset in mid-frame, and quiet idle behaviour.

module tb_dac_spi_tx;

   localparam int NDUT = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [11:0]       sdata [NDUT];
   logic [NDUT-1:0]   svalid;
   logic [NDUT-1:0]   sready, cs_n, sclk, mosi, ldac_n, busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Expected frames, one queue per instance.
   logic [15:0] exp_q [NDUT][$];

   // Monitor state and counters, one slot per instance.
   int          phase_err   [NDUT] = '{default: 0};
   int          mosi_err    [NDUT] = '{default: 0};
   int          frames_done [NDUT] = '{default: 0};
   int          ldac_falls  [NDUT] = '{default: 0};
   int          run         [NDUT] = '{default: 0};
   int          nbits       [NDUT] = '{default: 0};
   logic [15:0] mon_shift   [NDUT];
   logic        prev_sclk   [NDUT] = '{default: 1'b0};
   logic        prev_mosi   [NDUT] = '{default: 1'b0};
   logic        prev_ldac   [NDUT] = '{default: 1'b1};

   function automatic int hp_of(input int i);
      return (i == 0) ? 2 : (i == 1) ? 1 : 255;
   endfunction

   dac_spi_tx #(.HALF_PERIOD(2)) u_hp2 (
      .clk(clk), .rst_n(rst_n), .sample_data(sdata[0]), .sample_valid(svalid[0]),
      .sample_ready(sready[0]), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]),
      .dac_mosi(mosi[0]), .dac_ldac_n(ldac_n[0]), .busy(busy[0]));

   dac_spi_tx #(.HALF_PERIOD(1)) u_hp1 (
      .clk(clk), .rst_n(rst_n), .sample_data(sdata[1]), .sample_valid(svalid[1]),
      .sample_ready(sready[1]), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]),
      .dac_mosi(mosi[1]), .dac_ldac_n(ldac_n[1]), .busy(busy[1]));

   dac_spi_tx #(.HALF_PERIOD(255)) u_hp255 (
      .clk(clk), .rst_n(rst_n), .sample_data(sdata[2]), .sample_valid(svalid[2]),
      .sample_ready(sready[2]), .dac_cs_n(cs_n[2]), .dac_sclk(sclk[2]),
      .dac_mosi(mosi[2]), .dac_ldac_n(ldac_n[2]), .busy(busy[2]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame monitor, sampled on the falling clk edge, away from DUT updates.
   always @(negedge clk or negedge rst_n) begin
      logic [15:0] exp_frame;
      if (!rst_n) begin
         for (int i = 0; i < NDUT; i++) begin
            nbits[i]     = 0;
            run[i]       = 0;
            prev_sclk[i] = 1'b0;
            prev_ldac[i] = 1'b1;
         end
      end else begin
         for (int i = 0; i < NDUT; i++) begin
            if (prev_ldac[i] && !ldac_n[i]) ldac_falls[i]++;
            prev_ldac[i] = ldac_n[i];
            if (!cs_n[i]) begin
               if (sclk[i] && !prev_sclk[i]) begin
                  // The first rise follows SETUP plus a low phase, so its
                  // low-phase length is not checked.
                  if (nbits[i] != 0 && run[i] != hp_of(i)) phase_err[i]++;
                  mon_shift[i] = {mon_shift[i][14:0], mosi[i]};
                  nbits[i]++;
                  run[i] = 1;
                  if (nbits[i] == 16) begin
                     nbits[i] = 0;
                     frames_done[i]++;
                     check("frame_queue_depth", exp_q[i].size(), 1);
                     if (exp_q[i].size() > 0) begin
                        exp_frame = exp_q[i].pop_front();
                        check($sformatf("frame_data_dut%0d", i), mon_shift[i], exp_frame);
                     end
                  end
               end else if (!sclk[i] && prev_sclk[i]) begin
                  if (run[i] != hp_of(i)) phase_err[i]++;
                  run[i] = 1;
               end else begin
                  if (sclk[i] && (mosi[i] !== prev_mosi[i])) mosi_err[i]++;
                  run[i]++;
               end
            end else begin
               run[i] = 0;
            end
            prev_sclk[i] = sclk[i];
            prev_mosi[i] = mosi[i];
         end
      end
   end

   // Call just after an accepting edge. Follows the frame until ready returns
   // and checks cs_n, ldac_n and ready timing against HALF_PERIOD.
   task automatic measure(input int idx, input int hp, input bit toggle, input logic [11:0] new_data);
      int k, cs_low, ldac_low, first_ldac, fd0, pe0, me0;
      bit done;
      k = 0; cs_low = 0; ldac_low = 0; first_ldac = -1; done = 1'b0;
      fd0 = frames_done[idx]; pe0 = phase_err[idx]; me0 = mosi_err[idx];
      #1;
      svalid[idx] = 1'b0;
      sdata[idx]  = new_data;
      check("busy_after_accept", busy[idx], 1);
      check("ready_after_accept", sready[idx], 0);
      while (k < 36 * hp + 4) begin
         if (!cs_n[idx]) cs_low++;
         if (!ldac_n[idx]) begin
            ldac_low++;
            if (first_ldac < 0) first_ldac = k;
         end
         if (sready[idx]) begin
            done = 1'b1;
            break;
         end
         if (toggle && k > 0 && k < 60) svalid[idx] = ~svalid[idx];
         if (toggle && k == 60) svalid[idx] = 1'b0;
         @(posedge clk);
         #1;
         k++;
      end
      check("ready_returned", done, 1);
      check("ready_edge", k, 35 * hp);
      check("cs_low_cycles", cs_low, 34 * hp);
      check("ldac_low_cycles", ldac_low, hp);
      check("ldac_after_cs_rise", first_ldac, 34 * hp);
      check("frame_count", frames_done[idx], fd0 + 1);
      check("sclk_phase_len", phase_err[idx], pe0);
      check("mosi_stable_high", mosi_err[idx], me0);
      check("busy_after_frame", busy[idx], 0);
   endtask

   // Watchdog: stop the run if the sequence below stalls.
   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t_prev, idle_err, ld0, fd0;
      logic [11:0] codes [3];
      codes = '{12'h000, 12'hFFF, 12'h800};

      rst_n  = 1'b0;
      svalid = '0;
      for (int i = 0; i < NDUT; i++) sdata[i] = '0;

      // Values while held in reset.
      #6;
      for (int i = 0; i < NDUT; i++) begin
         check("rst_cs_n",   cs_n[i],   1);
         check("rst_sclk",   sclk[i],   0);
         check("rst_mosi",   mosi[i],   0);
         check("rst_ldac_n", ldac_n[i], 1);
         check("rst_busy",   busy[i],   0);
         check("rst_ready",  sready[i], 1);
      end

      // HP=2: sample 0xABC accepted on the first edge after reset is released.
      sdata[0]  = 12'hABC;
      svalid[0] = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      exp_q[0].push_back(16'h3ABC);
      measure(0, 2, 1'b0, 12'h0F0);

      // HP=2: data and valid change during a 0x123 frame.
      @(negedge clk);
      sdata[0]  = 12'h123;
      svalid[0] = 1'b1;
      @(posedge clk);
      exp_q[0].push_back(16'h3123);
      fd0 = frames_done[0];
      measure(0, 2, 1'b1, 12'h555);
      repeat (5) @(posedge clk);
      #1;
      check("single_accept_frames", frames_done[0], fd0 + 1);
      check("single_accept_idle", busy[0], 0);

      // HP=2: reset asserted while bit 7 is on the wire.
      @(negedge clk);
      sdata[0]  = 12'h2A5;
      svalid[0] = 1'b1;
      @(posedge clk);
      #1;
      svalid[0] = 1'b0;
      repeat (33) @(posedge clk);
      #3;
      check("cs_low_before_reset", cs_n[0], 0);
      ld0 = ldac_falls[0];
      fd0 = frames_done[0];
      rst_n = 1'b0;
      #1;
      check("async_rst_cs_n",   cs_n[0],   1);
      check("async_rst_sclk",   sclk[0],   0);
      check("async_rst_ldac_n", ldac_n[0], 1);
      check("async_rst_busy",   busy[0],   0);
      check("async_rst_ready",  sready[0], 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (80) @(posedge clk);
      #1;
      check("no_ldac_after_abort", ldac_falls[0], ld0);
      check("no_frame_after_abort", frames_done[0], fd0);
      @(negedge clk);
      sdata[0]  = 12'h7E1;
      svalid[0] = 1'b1;
      @(posedge clk);
      exp_q[0].push_back(16'h37E1);
      measure(0, 2, 1'b0, 12'h000);

      // Idle for 100 cycles with valid low on every instance.
      svalid   = '0;
      idle_err = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (cs_n !== '1 || sclk !== '0 || ldac_n !== '1 || busy !== '0 || sready !== '1)
            idle_err++;
      end
      check("idle_quiet_cycles", idle_err, 0);

      // HP=1: valid held high across three back-to-back frames.
      @(negedge clk);
      sdata[1]  = codes[0];
      svalid[1] = 1'b1;
      @(posedge clk);
      exp_q[1].push_back({4'h3, codes[0]});
      #1;
      t_prev   = cyc;
      sdata[1] = codes[1];
      check("b2b_busy", busy[1], 1);
      for (int f = 1; f < 3; f++) begin
         n = 0;
         while (!sready[1] && n < 60) begin
            @(posedge clk);
            #1;
            n++;
         end
         check("b2b_ready_edge", n, 35);
         @(posedge clk);
         exp_q[1].push_back({4'h3, codes[f]});
         #1;
         check("b2b_period", cyc - t_prev, 36);
         check("b2b_ready_one_cycle", sready[1], 0);
         t_prev = cyc;
         if (f < 2) sdata[1] = codes[f + 1];
      end
      svalid[1] = 1'b0;
      n = 0;
      while (!sready[1] && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("b2b_last_ready_edge", n, 35);
      check("b2b_frames", frames_done[1], 3);
      check("b2b_queue_empty", exp_q[1].size(), 0);

      // HP=255: code 0x001, long phases.
      @(negedge clk);
      sdata[2]  = 12'h001;
      svalid[2] = 1'b1;
      @(posedge clk);
      exp_q[2].push_back(16'h3001);
      measure(2, 255, 1'b0, 12'hFFE);

      check("hp2_queue_empty", exp_q[0].size(), 0);
      check("hp255_queue_empty", exp_q[2].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
